// File: rtl/hms_time_counter.sv
// 24-hour HH:MM:SS counter in packed BCD, advanced by qualified half-second ticks.
// All outputs registered; start/stop FSM gates ticks, set/clear inputs act in either state.
module hms_time_counter #(
  parameter int TICKS_PER_SECOND = 2,
  parameter bit INIT_RUNNING     = 1'b1
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       half_tick,
  input  logic       start_stop,
  input  logic       clear_sec,
  input  logic       set_min_inc,
  input  logic       set_hour_inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       blink,
  output logic       running,
  output logic       sec_pulse,
  output logic       day_wrap
);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  localparam state_t     RESET_STATE = INIT_RUNNING ? ST_RUNNING : ST_STOPPED;
  localparam logic [3:0] LAST_PHASE  = 4'(TICKS_PER_SECOND - 1);

  state_t     state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hour_q, hour_d;
  logic       blink_q, blink_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       day_wrap_q, day_wrap_d;

  logic qual_tick;
  logic sec_adv;
  logic sec_carry;
  logic min_carry;

  // Base-60 BCD increment, 59 -> 00.
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    if (start_stop) begin
      state_d = (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
    end
  end

  always_comb begin
    // Qualification uses the pre-toggle state so a same-cycle start_stop cannot affect it.
    qual_tick   = half_tick && (state_q == ST_RUNNING);
    sec_adv     = qual_tick && (phase_q == LAST_PHASE) && !clear_sec;
    sec_carry   = sec_adv && (sec_q == 8'h59);
    min_carry   = 1'b0;
    phase_d     = phase_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    blink_d     = qual_tick ? !blink_q : blink_q;
    sec_pulse_d = sec_adv;
    day_wrap_d  = 1'b0;

    if (clear_sec) begin
      phase_d = 4'd0;
      sec_d   = 8'h00;
    end else if (qual_tick) begin
      phase_d = (phase_q == LAST_PHASE) ? 4'd0 : phase_q + 4'd1;
      if (sec_adv) begin
        sec_d = inc_mod60(sec_q);
      end
    end

    // A manual set absorbs any carry arriving at the same digit pair.
    if (set_min_inc) begin
      min_d = inc_mod60(min_q);
    end else if (sec_carry) begin
      min_d     = inc_mod60(min_q);
      min_carry = (min_q == 8'h59);
    end

    if (set_hour_inc) begin
      hour_d = inc_hour(hour_q);
    end else if (min_carry) begin
      hour_d     = inc_hour(hour_q);
      day_wrap_d = (hour_q == 8'h23);
    end
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      phase_q     <= 4'd0;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= 8'h00;
      blink_q     <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      blink_q     <= blink_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
    end
  end

  assign sec_bcd   = sec_q;
  assign min_bcd   = min_q;
  assign hour_bcd  = hour_q;
  assign blink     = blink_q;
  assign running   = (state_q == ST_RUNNING);
  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;

endmodule

// File: doc/hms_time_counter.md
Name: hms_time_counter

Overview:
- Timekeeping core of the clock design; sits directly downstream of the half-second enable generator and consumes its one-cycle `hit` pulse as `half_tick`.
- Divides half ticks into seconds and keeps a 24-hour HH:MM:SS time in packed BCD.
- Provides a colon blink signal, start/stop control and manual set inputs for the display/driver stage.

Parameters:
- TICKS_PER_SECOND, 2, number of `half_tick` pulses per second (legal range 1..15).
- INIT_RUNNING, 1, FSM state entered on reset (1 = RUNNING, 0 = STOPPED).

Ports:
- ck  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- half_tick  input  1  one-cycle enable pulse from the half-second generator.
- start_stop  input  1  one-cycle pulse; toggles between RUNNING and STOPPED.
- clear_sec  input  1  one-cycle pulse; zeroes seconds and the tick phase.
- set_min_inc  input  1  one-cycle pulse; minutes +1.
- set_hour_inc  input  1  one-cycle pulse; hours +1.
- sec_bcd  output  8  seconds, [7:4] tens 0..5, [3:0] units 0..9.
- min_bcd  output  8  minutes, same encoding.
- hour_bcd  output  8  hours, [7:4] tens 0..2, [3:0] units 0..9, value 00..23.
- blink  output  1  colon blink; toggles on each qualified tick.
- running  output  1  1 while FSM is in RUNNING.
- sec_pulse  output  1  one-cycle pulse, asserted in the cycle seconds advanced.
- day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition.

Behaviour:
- All outputs are registered.
- Reset (sampled at a rising edge, overrides every other input, including mid-operation):
  - sec/min/hour = 00:00:00.
  - phase = 0, blink = 0, sec_pulse = 0, day_wrap = 0.
  - running = INIT_RUNNING.
- FSM has two states, STOPPED and RUNNING.
  - A `start_stop` pulse flips the state at the next edge.
  - Only a tick that arrives while the FSM is in RUNNING before that edge counts.
  - A `half_tick` in the same cycle as `start_stop` is qualified by the pre-toggle state.
- Qualified tick = half_tick & RUNNING. On a qualified tick:
  - blink toggles.
  - phase (4-bit) increments.
  - When phase == TICKS_PER_SECOND-1, phase returns to 0 and seconds advance.
- Latency: new digits, sec_pulse and day_wrap are all visible the cycle after the ck edge that sampled the qualifying half_tick.
- While STOPPED:
  - phase, blink and time hold.
  - Set inputs and clear_sec still act.
- Seconds advance (BCD):
  - Units 9 -> 0 with tens +1.
  - 59 -> 00 with carry into minutes.
- Minutes advance the same way; 59 -> 00 carries into hours.
- Hours: 09 -> 10, 19 -> 20, 23 -> 00.
- day_wrap = 1 exactly when the carry chain takes 23:59:59 to 00:00:00.
- sec_pulse = 1 for every seconds advance, including wraps.
- clear_sec:
  - Sets seconds = 00 and phase = 0.
  - Has priority over a same-cycle seconds advance: no advance, no carry, sec_pulse = 0.
  - blink is unaffected.
- set_min_inc:
  - Minutes +1 with 59 -> 00 wrap and no carry into hours.
  - If a seconds carry into minutes occurs in the same cycle, minutes still change by exactly +1 (the carry is absorbed). Seconds still wrap and sec_pulse still fires.
- set_hour_inc:
  - Hours +1 with 23 -> 00 wrap; never asserts day_wrap.
  - A same-cycle carry into hours is absorbed the same way.
- day_wrap from a carry is suppressed if set_min_inc or set_hour_inc absorbed that carry.
- Set inputs held high for N cycles produce N increments; no edge detection inside the block.
- BCD digits never leave legal ranges. No binary intermediate is exposed.

Test Plan:
- Reset, then 2 half_ticks spaced 10 cycles apart in RUNNING → after 1st: blink = 1, sec = 00; after 2nd: blink = 0, sec = 01, sec_pulse high for exactly 1 cycle, 1 cycle after the tick.
- Preload via set inputs to 23:59 and run to sec = 59, then 2 half_ticks → 00:00:00, day_wrap = 1 for 1 cycle, sec_pulse = 1 same cycle.
- start_stop pulse, then 6 half_ticks → running = 0, time and blink unchanged; another start_stop plus 2 half_ticks → sec +1.
- At 00:00:59 with phase = 1, half_tick together with set_min_inc → 00:01:00 (not 00:02), sec_pulse = 1; repeat with clear_sec instead of set_min_inc → 00:00:00, sec_pulse = 0.
- set_hour_inc pulsed 24 times from 00 → hours sequence 01..09, 10..19, 20..23, 00; day_wrap never asserted; 12 set_min_inc pulses at min 55 → 56..59, 00..07, hours unchanged.
- Assert reset mid-count (time 12:34:56, blink = 1) together with a half_tick → next cycle all outputs at reset values, running = INIT_RUNNING.
